// File: rtl/mux_nway_rr_pkg.sv
// Shared constants and helpers for the registered N-way round-robin mux.
package mux_nway_rr_pkg;

    // Operating modes selected by the MODE parameter.
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Ceiling log2, used to validate the select/grant index width.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter with optional grant lock.
// The search starts just after the last granted channel and wraps modulo N.
module rr_arbiter_n #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [SEL_W-1:0] last_grant_i,
    input  logic             lock_i,
    output logic [SEL_W-1:0] grant_o,
    output logic             any_req_o
);

    // Requests padded to the full index range so any index value is legal.
    localparam int SPAN = 1 << SEL_W;

    logic [SPAN-1:0]  req_pad;
    logic             found;
    logic [SEL_W-1:0] idx;

    assign req_pad   = SPAN'(req_i);
    assign any_req_o = |req_i;

    // Lock keeps the previous owner while it still requests; otherwise the
    // first requester after last_grant wins.
    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        grant_o = last_grant_i;
        found   = 1'b0;
        idx     = '0;
        if (lock_i && req_pad[last_grant_i]) begin
            found = 1'b1;
        end
        for (int k = 1; k <= N; k++) begin
            idx = SEL_W'((int'(last_grant_i) + k) % N);
            if (!found && req_pad[idx]) begin
                grant_o = idx;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nway_rr.sv
// Registered N-way, WIDTH-bit multiplexer with valid/ready on every channel.
// MODE_FIXED takes the channel from sel; MODE_RR arbitrates round-robin with
// an optional lock for bursts. A single output register gives full
// throughput while the consumer is ready.
module mux_nway_rr
    import mux_nway_rr_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int SEL_W = 2,
    parameter int MODE  = MODE_FIXED
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 lock,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int               SPAN       = 1 << SEL_W;
    localparam logic [SEL_W-1:0] LAST_RESET = SEL_W'(N - 1);

    if (SEL_W != clog2(N)) begin : g_bad_sel_w
        $error("mux_nway_rr: SEL_W must equal clog2(N)");
    end

    logic [WIDTH-1:0] out_data_q,   out_data_d;
    logic [SEL_W-1:0] out_sel_q,    out_sel_d;
    logic             out_valid_q,  out_valid_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;

    logic             accept;
    logic             request;
    logic             transfer;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] arb_grant;
    logic             arb_any;
    logic [SPAN-1:0]  valid_pad;
    logic [WIDTH-1:0] sel_data;

    // The output register can take a new word when empty or being drained.
    assign accept    = !out_valid_q || out_ready;
    // Out-of-range sel values (non-power-of-two N) read a zero request bit.
    assign valid_pad = SPAN'(in_valid);

    rr_arbiter_n #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arbiter (
        .req_i        (in_valid),
        .last_grant_i (last_grant_q),
        .lock_i       (lock),
        .grant_o      (arb_grant),
        .any_req_o    (arb_any)
    );

    // Pick the grant source for the configured mode.
    always_comb begin
        if (MODE == MODE_RR) begin
            grant   = arb_grant;
            request = arb_any;
        end else begin
            grant   = sel;
            request = valid_pad[sel];
        end
    end

    // One-hot ready towards the granted channel; held low during reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (!reset && accept && request && (grant == SEL_W'(i))) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    assign transfer = |(in_valid & in_ready);

    // Data path: only the granted channel's word can reach the register.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SEL_W'(i)) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next state: load on transfer, drain on consumer ready, else hold.
    always_comb begin
        out_data_d   = out_data_q;
        out_sel_d    = out_sel_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        if (transfer) begin
            out_data_d   = sel_data;
            out_sel_d    = grant;
            out_valid_d  = 1'b1;
            last_grant_d = grant;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    // Output and pointer registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q   <= '0;
            out_sel_q    <= '0;
            out_valid_q  <= 1'b0;
            last_grant_q <= LAST_RESET;
        end else begin
            out_data_q   <= out_data_d;
            out_sel_q    <= out_sel_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule
